fifo_pop_stage: RTL
===================

// Module: fifo_pop_stage
// PURPOSE
//  Downstream drain stage for the FIFO block: pops entries through the FIFO's push/pop/empty
//  interface and re-presents them on a valid/ready stream. Holds up to two entries (skid buffer),
//  so fifo_pop never depends combinationally on out_ready. It keeps the FIFO's
//  combinational read-data path out of downstream timing.
// PARAMETERS
//  WIDTH     8   data width; matches FIFO WIDTH
//  STALL_W   16  width of optional stall counter (STALL_CNT_EN only)
// PORTS
//  clk         in   1        clock; all state on posedge
//  rst_n       in   1        reset, asynchronous, active-low
//  flush       in   1        sync: discard held entries this cycle
//  fifo_empty  in   1        FIFO empty flag
//  fifo_data   in   WIDTH    FIFO data_out (combinational, valid whenever !fifo_empty)
//  fifo_pop    out  1        pop strobe to FIFO
//  out_valid   out  1        downstream data valid
//  out_ready   in   1        downstream accept
//  out_data    out  WIDTH    downstream data (head entry)
//  stall_cnt   out  STALL_W  cycles with out_valid & !out_ready (STALL_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=EMPTY, out_valid=0, out_data=0, fifo_pop=0, both slots=0, stall_cnt=0.
//  - Slots: head (drives out_data) and tail. FSM state = occupancy: EMPTY(0), ONE(1), TWO(2).
//  - fifo_pop = !fifo_empty & !flush & (state!=TWO). Comb. from state/fifo_empty/flush only, never out_ready.
//    Never asserted while fifo_empty=1, because the FIFO has no underflow guard.
//  - in_fire = fifo_pop; data captured = fifo_data in the same cycle (FIFO updates rdPtr at that edge).
//  - out_fire = out_valid & out_ready; out_valid = (state!=EMPTY). Both registered, no comb. path to out_ready.
//  - Transitions (flush=0):
//     EMPTY: in_fire -> ONE (head<=fifo_data); else EMPTY.
//     ONE:   in&out -> ONE (head<=fifo_data); in only -> TWO (tail<=fifo_data);
//            out only -> EMPTY; neither -> ONE.
//     TWO:   out_fire -> ONE (head<=tail); else TWO (no pop).
//  - Latency: FIFO non-empty at cycle N with stage EMPTY -> out_valid=1 at N+1 with that data.
//  - Throughput: 1 entry/cycle sustained when out_ready=1 (steady state ONE).
//  - Ordering: strict FIFO order; no duplication or loss except under flush.
//  - flush=1: state<=EMPTY next edge, fifo_pop=0, out_valid drops next cycle. An out_fire in the same cycle
//    still counts as a transfer. FIFO contents untouched (flush FIFO via its own rst).
//  - Reset mid-transfer: held entries discarded; no pop until rst_n released and fifo_empty=0.
//  - out_data holds its value while out_valid=0. Only slot writes change it.
// CONFIGURATION
//  STALL_CNT_EN defined: stall_cnt increments each cycle with out_valid & !out_ready, saturates at
//    2^STALL_W-1, clears on reset only (not flush).
//  STALL_CNT_EN undefined: stall_cnt port and counter logic absent. Datapath identical.
// STRUCTURE
//  - Shared package fifo_pkg: typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_TWO} occ_e;
//    default WIDTH constant shared with FIFO.
//  - Slot registers reuse the codebase FF cell (en = slot write). Add an async-low reset variant if FF lacks one.
//  - Optional sub-module: sat_counter (STALL_W-bit saturating counter) for STALL_CNT_EN.
//  - No further hierarchy: FSM + 2 slots inline.
// TESTING (bench: FIFO WIDTH=8 DEPTH=8 feeding this stage)
//  1 Push 0x11,0x22,0x33; out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles; first valid 1 cycle after FIFO non-empty.
//  2 out_ready=0, FIFO holds 5 -> exactly 2 pops then fifo_pop=0, state TWO, out_data=first word;
//    raise out_ready -> all 5 out in order, no gaps.
//  3 FIFO empty throughout -> fifo_pop never 1, out_valid stays 0. Random pushes with random out_ready:
//    scoreboard order matches, fifo_pop never with fifo_empty.
//  4 State TWO, flush=1 with out_ready=0 -> next cycle out_valid=0, no pop in flush cycle, next FIFO word delivered after.
//  5 rst_n low mid-stream (async, off-edge) -> out_valid, fifo_pop, out_data =0 immediately; resume cleanly after release.
//  6 STALL_CNT_EN, STALL_W=4: hold out_ready=0 with out_valid=1 for 20 cycles -> stall_cnt=15 (saturated); unchanged by flush.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default data width and drain-stage occupancy encoding.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/ff_en_ar.sv
// Codebase FF cell: W-bit register with write enable and async active-low clear.
module ff_en_ar #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sat_counter.sv
// W-bit up-counter that sticks at all-ones; cleared only by async reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_pop_stage.sv
// Two-entry skid drain stage between a FIFO pop interface and a valid/ready stream.
// Optional stall counter enabled by defining STALL_CNT_EN.
module fifo_pop_stage
  import fifo_pkg::*;
#(
  parameter int WIDTH   = FIFO_WIDTH,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               fifo_empty,
  input  logic [WIDTH-1:0]   fifo_data,
  output logic               fifo_pop,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef STALL_CNT_EN
  ,
  output logic [STALL_W-1:0] stall_cnt
`endif
);

  occ_e             state;
  occ_e             state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             head_we;
  logic             tail_we;
  logic [WIDTH-1:0] head_d;
  logic [WIDTH-1:0] tail_q;

  // Pop depends only on occupancy, so out_ready never reaches the FIFO combinationally.
  // rst_n gates it so nothing is popped while the stage is held in reset.
  assign fifo_pop  = rst_n & ~fifo_empty & ~flush & (state != OCC_TWO);
  assign in_fire   = fifo_pop;
  assign out_valid = (state != OCC_EMPTY);
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = OCC_EMPTY;
    end else begin
      case (state)
        OCC_EMPTY: if (in_fire) state_nxt = OCC_ONE;
        OCC_ONE: begin
          if (in_fire && !out_fire)      state_nxt = OCC_TWO;
          else if (!in_fire && out_fire) state_nxt = OCC_EMPTY;
        end
        OCC_TWO:   if (out_fire) state_nxt = OCC_ONE;
        default:   state_nxt = OCC_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Head is refilled from the FIFO or promoted from tail; flush suppresses promotion
  // so out_data stays put while the stage is emptied.
  assign head_we = ~flush & (((state == OCC_EMPTY) & in_fire) |
                             ((state == OCC_ONE) & in_fire & out_fire) |
                             ((state == OCC_TWO) & out_fire));
  assign head_d  = (state == OCC_TWO) ? tail_q : fifo_data;
  assign tail_we = (state == OCC_ONE) & in_fire & ~out_fire;

  ff_en_ar #(.W(WIDTH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (head_we),
    .d     (head_d),
    .q     (out_data)
  );

  ff_en_ar #(.W(WIDTH)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tail_we),
    .d     (fifo_data),
    .q     (tail_q)
  );

`ifdef STALL_CNT_EN
  sat_counter #(.W(STALL_W)) u_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .count (stall_cnt)
  );
`else
  logic unused_stall_w;
  assign unused_stall_w = (STALL_W > 0);
`endif

endmodule
